// File: rtl/sram_access_arbiter_if.sv
// Requester and SRAM-pin bundle for the framebuffer SRAM arbiter.
// master: the requesters and SRAM model side; slave: the arbiter.
interface sram_access_arbiter_if;
  logic        rd_req;
  logic [17:0] rd_addr;
  logic        rd_ack;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        wr_req;
  logic [17:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        busy;
  logic [17:0] sram_addr;
  logic [15:0] sram_dout;
  logic [15:0] sram_din;
  logic        sram_drive;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, sram_din,
    input  rd_ack, rd_valid, rd_data, wr_ack, busy,
           sram_addr, sram_dout, sram_drive, sram_ce_n, sram_oe_n, sram_we_n
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, sram_din,
    output rd_ack, rd_valid, rd_data, wr_ack, busy,
           sram_addr, sram_dout, sram_drive, sram_ce_n, sram_oe_n, sram_we_n
  );
endinterface

// File: rtl/sram_access_arbiter.sv
// Framebuffer SRAM arbiter: shares one async SRAM between the display read
// port and the capture write port, and times the strobes of each access.
// Reads win ties; a bounded read streak forces a pending write through.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | strobes released, arbitrating between rd_req and wr_req
// RD       | ce_n/oe_n low for ACCESS_CYCLES, data captured on last one
// WR_SETUP | ce_n low, data driven, we_n still high (address setup)
// WR_PULSE | we_n low for ACCESS_CYCLES
// WR_HOLD  | we_n high again, data and address held for one cycle
module sram_access_arbiter #(
  parameter int unsigned ACCESS_CYCLES   = 2,
  parameter int unsigned MAX_READ_STREAK = 3
) (
  input  logic                  sysClk,
  input  logic                  reset,
  sram_access_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;

  localparam logic [3:0] TMR_LOAD   = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_READ_STREAK);

  state_t      state_q, state_d;
  logic [3:0]  timer_q, timer_d;
  logic [3:0]  streak_q, streak_d;
  logic        grant_rd, grant_wr;

  logic        ce_n_q, oe_n_q, we_n_q, drive_q, busy_q;
  logic        rd_ack_q, wr_ack_q, rd_valid_q;
  logic [17:0] addr_q;
  logic [15:0] dout_q, rd_data_q;

  logic        ce_n_d, oe_n_d, we_n_d, drive_d, busy_d;
  logic        rd_ack_d, wr_ack_d, rd_valid_d;
  logic [17:0] addr_d;
  logic [15:0] dout_d, rd_data_d;

  // State register with strobe timer and read-streak counter
  always_ff @(posedge sysClk) begin
    if (reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      streak_q <= streak_d;
    end
  end

  // Next-state logic: arbitration in IDLE, terminal-count exits elsewhere
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    streak_d = streak_q;
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rd_req && !(bus.wr_req && streak_q == STREAK_MAX)) grant_rd = 1'b1;
        else if (bus.wr_req) grant_wr = 1'b1;
        if (grant_rd) begin
          state_d = RD;
          timer_d = TMR_LOAD;
        end else if (grant_wr) begin
          state_d = WR_SETUP;
        end
        // Only reads that keep a write waiting count toward the streak
        if (!bus.wr_req || grant_wr) streak_d = '0;
        else if (grant_rd && streak_q != STREAK_MAX) streak_d = streak_q + 4'd1;
      end
      RD: begin
        if (timer_q == 4'd0) state_d = IDLE;
        else timer_d = timer_q - 4'd1;
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        timer_d = TMR_LOAD;
      end
      WR_PULSE: begin
        if (timer_q == 4'd0) state_d = WR_HOLD;
        else timer_d = timer_q - 4'd1;
      end
      WR_HOLD:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output decode: strobes follow the state being entered so they are registered
  always_comb begin
    ce_n_d     = (state_d == IDLE);
    oe_n_d     = (state_d != RD);
    we_n_d     = (state_d != WR_PULSE);
    drive_d    = (state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == WR_HOLD);
    busy_d     = (state_d != IDLE);
    rd_ack_d   = grant_rd;
    wr_ack_d   = grant_wr;
    addr_d     = addr_q;
    dout_d     = dout_q;
    if (grant_rd) addr_d = bus.rd_addr;
    if (grant_wr) begin
      addr_d = bus.wr_addr;
      dout_d = bus.wr_data;
    end
    rd_valid_d = (state_q == RD) && (timer_q == 4'd0);
    rd_data_d  = rd_valid_d ? bus.sram_din : rd_data_q;
  end

  // Output registers; reset releases all strobes at once, aborting any access
  always_ff @(posedge sysClk) begin
    if (reset) begin
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      drive_q    <= 1'b0;
      busy_q     <= 1'b0;
      rd_ack_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      addr_q     <= '0;
      dout_q     <= '0;
      rd_data_q  <= '0;
    end else begin
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      drive_q    <= drive_d;
      busy_q     <= busy_d;
      rd_ack_q   <= rd_ack_d;
      wr_ack_q   <= wr_ack_d;
      rd_valid_q <= rd_valid_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.sram_ce_n  = ce_n_q;
  assign bus.sram_oe_n  = oe_n_q;
  assign bus.sram_we_n  = we_n_q;
  assign bus.sram_drive = drive_q;
  assign bus.busy       = busy_q;
  assign bus.rd_ack     = rd_ack_q;
  assign bus.wr_ack     = wr_ack_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_dout  = dout_q;
  assign bus.rd_data    = rd_data_q;

endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
- Owns the single framebuffer SRAM and shares it between two requesters: the capture-side write port (AIV pixels in) and the display-side read port (Pi pixels out).
- Sequences async-SRAM read and write cycles (setup/strobe/hold) and guarantees strobe timing.
- Read has priority, because display underrun is visible. A bounded read streak prevents write starvation.
- Sits between the framebuffer line FIFOs and the SRAM0 pins.

Parameters:
- ACCESS_CYCLES, 2, sysClk cycles of asserted oe_n/we_n per access; legal range 1..15.
- MAX_READ_STREAK, 3, consecutive read grants allowed while a write is pending before a write is forced; legal range 1..15.

Ports:
- sysClk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_req  in  1  read request; held high until rd_ack.
- rd_addr  in  18  read word address; sampled on grant.
- rd_ack  out  1  1-cycle pulse: read accepted.
- rd_valid  out  1  1-cycle pulse: rd_data is valid.
- rd_data  out  16  read word; holds its value until the next rd_valid.
- wr_req  in  1  write request; held high until wr_ack.
- wr_addr  in  18  write word address; sampled on grant.
- wr_data  in  16  write word; sampled on grant.
- wr_ack  out  1  1-cycle pulse: write accepted.
- busy  out  1  high whenever the FSM is not in IDLE.
- sram_addr  out  18  SRAM address.
- sram_dout  out  16  SRAM write data.
- sram_din  in  16  SRAM read data.
- sram_drive  out  1  tristate enable for sram_dout; the top level builds the inout.
- sram_ce_n  out  1  chip enable, active low.
- sram_oe_n  out  1  output enable, active low.
- sram_we_n  out  1  write enable, active low.

Behaviour:
- Reset values (reset high at an edge):
  - FSM goes to IDLE.
  - sram_ce_n, sram_oe_n, sram_we_n = 1; sram_drive = 0.
  - sram_addr, sram_dout, rd_data = 0.
  - rd_ack, wr_ack, rd_valid, busy = 0.
  - Streak counter = 0.
- Reset mid-operation aborts the access immediately. Strobes are deasserted at that edge, and no rd_valid or ack is issued for the aborted access.
- All outputs are registered.
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
- Arbitration (IDLE only, at edge t):
  - Only rd_req high: grant read.
  - Only wr_req high: grant write.
  - Both high: grant write if streak == MAX_READ_STREAK, otherwise grant read.
- Streak counter:
  - Increments on each read grant made while wr_req is high.
  - Clears on any write grant, or on any IDLE cycle with wr_req low.
  - Saturates at MAX_READ_STREAK.
- Read grant at edge t:
  - rd_ack = 1 for cycle t+1; addr latched to sram_addr.
  - State RD for cycles t+1..t+ACCESS_CYCLES with ce_n = 0, oe_n = 0, we_n = 1, drive = 0.
  - sram_din captured into rd_data at the end of cycle t+ACCESS_CYCLES.
  - rd_valid = 1 in cycle t+ACCESS_CYCLES+1; ce_n and oe_n return to 1; FSM is back in IDLE.
  - Read period is ACCESS_CYCLES+1 cycles.
- Write grant at edge t:
  - wr_ack = 1 for cycle t+1; addr and data latched.
  - WR_SETUP (1 cycle): ce_n = 0, drive = 1, we_n = 1.
  - WR_PULSE (ACCESS_CYCLES cycles): we_n = 0.
  - WR_HOLD (1 cycle): we_n = 1, ce_n = 0, drive = 1.
  - Then IDLE, with ce_n = 1 and drive = 0.
  - Write period is ACCESS_CYCLES+3 cycles.
- Invariants:
  - oe_n = 0 and drive = 1 never occur in the same cycle.
  - we_n = 0 only while drive = 1 and the address is stable.
  - sram_addr changes only on a grant.
- Requester rules:
  - Requesters may drop or change req, addr and data in the cycle ack is seen.
  - A req still high in the IDLE cycle after completion is treated as a new request.
  - A request deasserted before ack is never granted and is not an error.
- busy = 1 in every non-IDLE state.

Test Plan:
- Single read, ACCESS_CYCLES=2:
  - Stimulus: rd_req with rd_addr=0x1_2345; sram_din=0xBEEF.
  - Required: rd_ack at t+1; ce_n/oe_n low for 2 cycles; rd_valid at t+3 with rd_data=0xBEEF; we_n stays 1.
- Single write:
  - Stimulus: wr_addr=0x3FFFF, wr_data=0xA5A5.
  - Required: wr_ack at t+1; drive high t+1..t+4; we_n low t+2..t+3 only; sram_dout=0xA5A5 throughout.
- Both requests held continuously, MAX_READ_STREAK=3:
  - Required: grant order R,R,R,W,R,R,R,W; no grant gap larger than one write period.
- Simultaneous first request with streak=0:
  - Required: read granted first; wr_ack arrives after exactly 3 reads.
- Reset asserted in RD cycle 1:
  - Required: next cycle ce_n = oe_n = 1, rd_valid = 0, busy = 0; a subsequent read completes normally.
- Reset asserted in WR_PULSE:
  - Required: we_n = 1 and drive = 0 at the next cycle; no wr_ack is generated afterwards without a new request.
